vga_pattern_ctrl: RTL
=====================

// Module: vga_pattern_ctrl
// PURPOSE
//  Test-pattern controller for the 3-bit VGA path: consumes vga_sync timing (p_tick, video_on, pixel_x/y) and drives rgb.
//  Sequences five patterns, manually from a step button or automatically every DWELL_FRAMES frames.
//  Mode changes take effect only at frame start (no tearing). Sits between vga_sync and the board rgb pins in test tops.
// PARAMETERS
//  H_ACTIVE      640  visible pixels per line
//  V_ACTIVE      480  visible lines per frame
//  BAR_W         80   width in pixels of one vertical colour bar
//  DWELL_FRAMES  120  frames per pattern in auto mode (2 s at 60 Hz); min 1
// PORTS
//  clk         in   1   system clock (same as vga_sync)
//  reset       in   1   asynchronous, active-low reset
//  p_tick      in   1   pixel enable from vga_sync, one clk wide
//  video_on    in   1   visible-area flag from vga_sync
//  pixel_x     in   10  current pixel column
//  pixel_y     in   10  current pixel row
//  sw          in   3   solid colour for SOLID mode
//  auto_en     in   1   level: 1 = auto-advance, 0 = manual
//  btn_step    in   1   raw, asynchronous step button, active-high
//  rgb         out  3   registered pixel colour
//  mode        out  3   active pattern index 0..4
//  frame_tick  out  1   one-clk pulse at frame start
// BEHAVIOUR
//  Reset (reset=0): rgb=0, mode=0 (SOLID), frame_tick=0, FSM=MANUAL, dwell_cnt=0, step_pend=0, bar counters=0.
//  Frame start: p_tick && pixel_x==0 && pixel_y==0; frame_tick is registered, high for the clk after it.
//  Patterns (mode): 0 SOLID = sw; 1 VBARS = bar_idx (bar_idx += 1 every BAR_W pixels, cleared at pixel_x==0, saturates at 7);
//   2 HBARS = pixel_y[8:6]; 3 CHECKER = (pixel_x[5]^pixel_y[5]) ? 3'b111 : 3'b000;
//   4 BORDER = 3'b111 when x==0, x==H_ACTIVE-1, y==0 or y==V_ACTIVE-1, else 3'b000.
//  rgb is updated on p_tick only, one clk latency from pixel_x/y; rgb=0 whenever video_on=0 at that p_tick.
//  btn_step: 2-flop sync then rising-edge detect; the edge sets step_pend (sticky; extra edges before apply are ignored).
//  FSM states: MANUAL, AUTO.
//   MANUAL: at frame start, if step_pend then mode advances and step_pend clears. auto_en=1 -> AUTO, dwell_cnt=0.
//   AUTO: at frame start, dwell_cnt++; on reaching DWELL_FRAMES-1, mode advances and dwell_cnt=0.
//    At frame start, step_pend also advances mode and clears dwell_cnt. auto_en=0 -> MANUAL, dwell_cnt=0, mode held.
//  Advance: mode 0->1->2->3->4->0 (wrap at 4). Step and dwell expiry at the same frame start: exactly one advance.
//  Mode never changes mid-frame; frame_tick and mode update are coincident.
//  Reset mid-frame: all state as above; patterns resume from the next p_tick with mode 0; first advance at the next full frame start.
//  dwell_cnt width = $clog2(DWELL_FRAMES+1). bar_idx is 3 bits. Only rgb's registered output reaches the pins.
// CONFIGURATION
//  VGA_PATTERN_CROSSHAIR_EN defined: white (3'b111) 1-pixel crosshair at x==H_ACTIVE/2 or y==V_ACTIVE/2.
//   It overlays every mode and is still gated by video_on.
//  Undefined: no overlay logic; rgb is exactly the pattern above.
// STRUCTURE
//  vga_pattern_pkg.vh: mode encodings (MODE_SOLID..MODE_BORDER, MODE_LAST=4), FSM state codes, COLOR_WHITE/COLOR_BLACK.
//  Sub-module btn_step_sync: 2-flop synchroniser + rising-edge pulse, async active-low reset, output 0 in reset.
//  The rest (FSM, dwell counter, bar counter, pattern mux, rgb register) is inline.
// TESTING
//  1 reset=0 mid-line, then release -> rgb=0, mode=0, frame_tick=0 in reset; after release with sw=3'b101, visible rgb=3'b101.
//  2 auto_en=0, btn_step pulse mid-frame -> mode unchanged until next frame start, then 0->1; 3 pulses in one frame -> single advance.
//  3 auto_en=1, DWELL_FRAMES=2 -> mode 0,1,2,3,4,0 advancing every 2 frame_ticks; wrap 4->0 is checked.
//  4 auto_en=1 with step and dwell expiry at the same frame start -> mode +1 only, dwell_cnt=0.
//  5 mode=1 -> bar_idx 0 for x=0..79 and 1 at x=80; rgb lags pixel_x by 1 clk; rgb=0 when video_on=0.
//  6 with VGA_PATTERN_CROSSHAIR_EN, mode=0, sw=0 -> rgb=3'b111 only at x=320 or y=240; without the macro, rgb=0 everywhere.

Source files
------------

// File: rtl/vga_pattern_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vga_pattern_ctrl_pkg
//   Shared definitions for the VGA test-pattern controller.
//   Pattern mode encodings, sequencer FSM states, fixed colours, and the
//   mode-advance helper (0 -> 1 -> 2 -> 3 -> 4 -> 0).
// -----------------------------------------------------------------------------
package vga_pattern_ctrl_pkg;

   typedef enum logic [2:0] {
      MODE_SOLID   = 3'd0,
      MODE_VBARS   = 3'd1,
      MODE_HBARS   = 3'd2,
      MODE_CHECKER = 3'd3,
      MODE_BORDER  = 3'd4
   } mode_e;

   localparam mode_e MODE_LAST = MODE_BORDER;

   typedef enum logic {
      ST_MANUAL = 1'b0,
      ST_AUTO   = 1'b1
   } state_e;

   localparam logic [2:0] COLOR_WHITE = 3'b111;
   localparam logic [2:0] COLOR_BLACK = 3'b000;

   // Next pattern in the sequence, wrapping after MODE_LAST.
   function automatic mode_e next_mode(input mode_e m);
      mode_e n;
      case (m)
         MODE_SOLID:   n = MODE_VBARS;
         MODE_VBARS:   n = MODE_HBARS;
         MODE_HBARS:   n = MODE_CHECKER;
         MODE_CHECKER: n = MODE_BORDER;
         default:      n = MODE_SOLID;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/vga_pattern_ctrl_btn_step_sync.sv
// -----------------------------------------------------------------------------
// vga_pattern_ctrl_btn_step_sync
//   Step-button conditioner: two-flop synchroniser followed by a rising-edge
//   detector. Produces a registered one-clk pulse per press.
// Ports:
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset (pulse_o = 0 while asserted)
//   btn_i    in  raw asynchronous button, active-high
//   pulse_o  out one-clk pulse on each synchronised rising edge
// -----------------------------------------------------------------------------
module vga_pattern_ctrl_btn_step_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic pulse_o
);

   logic sync1_q, sync2_q, prev_q, pulse_q;

   // NOTE: sequential state is written with non-blocking (<=) so every flop
   // samples the pre-edge value of its neighbours; blocking here would collapse
   // the synchroniser chain into a single stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         pulse_q <= sync2_q & ~prev_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/vga_pattern_ctrl.sv
// -----------------------------------------------------------------------------
// vga_pattern_ctrl
//   Test-pattern generator for the 3-bit VGA path. Consumes vga_sync timing
//   and drives a registered rgb value. Five patterns (SOLID, VBARS, HBARS,
//   CHECKER, BORDER) are stepped manually via btn_step or automatically every
//   DWELL_FRAMES frames. Pattern changes only happen at frame start.
//
// Optional build macro:
//   VGA_PATTERN_CROSSHAIR_EN  overlay a white 1-pixel crosshair at
//                             x == H_ACTIVE/2 or y == V_ACTIVE/2 (still gated
//                             by video_on). Undefined: no overlay logic.
//
// Ports:
//   clk         in   system clock (shared with vga_sync)
//   reset       in   asynchronous active-low reset
//   p_tick      in   pixel enable, one clk wide
//   video_on    in   visible-area flag
//   pixel_x     in   [9:0] current column
//   pixel_y     in   [9:0] current row
//   sw          in   [2:0] colour for SOLID mode
//   auto_en     in   level: 1 = auto-advance, 0 = manual stepping
//   btn_step    in   raw asynchronous step button, active-high
//   rgb         out  [2:0] registered pixel colour
//   mode        out  [2:0] active pattern index 0..4
//   frame_tick  out  one-clk pulse, coincident with any mode update
// -----------------------------------------------------------------------------
module vga_pattern_ctrl
   import vga_pattern_ctrl_pkg::*;
#(
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int BAR_W        = 80,
   parameter int DWELL_FRAMES = 120
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       p_tick,
   input  logic       video_on,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   input  logic [2:0] sw,
   input  logic       auto_en,
   input  logic       btn_step,
   output logic [2:0] rgb,
   output logic [2:0] mode,
   output logic       frame_tick
);

   localparam int DW = $clog2(DWELL_FRAMES + 1);
   localparam int CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

   localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_FRAMES - 1);
   localparam logic [CW-1:0] BAR_LAST   = CW'(BAR_W - 1);
   localparam logic [9:0]    X_LAST     = 10'(H_ACTIVE - 1);
   localparam logic [9:0]    Y_LAST     = 10'(V_ACTIVE - 1);

   // ------------------------------------------------------------------------
   // Step button conditioning
   // ------------------------------------------------------------------------
   logic step_pulse;

   vga_pattern_ctrl_btn_step_sync u_btn_sync (
      .clk     (clk),
      .rst_n   (reset),
      .btn_i   (btn_step),
      .pulse_o (step_pulse)
   );

   // ------------------------------------------------------------------------
   // Sequencer state
   // ------------------------------------------------------------------------
   state_e        state_q, state_d;
   mode_e         mode_q, mode_d;
   logic [DW-1:0] dwell_q, dwell_d;
   logic          step_pend_q, step_pend_d;
   logic          frame_tick_q;
   logic          frame_start;

   assign frame_start = p_tick && (pixel_x == 10'd0) && (pixel_y == 10'd0);

   // NOTE: every variable driven here gets a default first so no path leaves
   // it unassigned; a missing default infers a latch.
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      dwell_d     = dwell_q;
      // A press is sticky; further presses before it is applied change nothing.
      step_pend_d = step_pend_q | step_pulse;

      case (state_q)
         ST_MANUAL: begin
            if (frame_start && step_pend_q) begin
               mode_d      = next_mode(mode_q);
               step_pend_d = step_pulse;
            end
            if (auto_en) begin
               state_d = ST_AUTO;
               dwell_d = '0;
            end
         end

         ST_AUTO: begin
            if (!auto_en) begin
               // Leaving auto: hold the current pattern, restart dwell later.
               state_d = ST_MANUAL;
               dwell_d = '0;
            end else if (frame_start) begin
               // A pending step wins over dwell expiry; both together still
               // give a single advance.
               if (step_pend_q) begin
                  mode_d      = next_mode(mode_q);
                  step_pend_d = step_pulse;
                  dwell_d     = '0;
               end else if (dwell_q == DWELL_LAST) begin
                  mode_d  = next_mode(mode_q);
                  dwell_d = '0;
               end else begin
                  dwell_d = dwell_q + DW'(1);
               end
            end
         end

         default: state_d = ST_MANUAL;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_MANUAL;
         mode_q       <= MODE_SOLID;
         dwell_q      <= '0;
         step_pend_q  <= 1'b0;
         frame_tick_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         mode_q       <= mode_d;
         dwell_q      <= dwell_d;
         step_pend_q  <= step_pend_d;
         frame_tick_q <= frame_start;
      end
   end

   // ------------------------------------------------------------------------
   // Vertical bar index: tracks pixel_x in BAR_W-wide steps, one step per
   // p_tick, restarting at column 0 and saturating at the last colour.
   // ------------------------------------------------------------------------
   logic [CW-1:0] bar_cnt_q, bar_cnt_d;
   logic [2:0]    bar_idx_q, bar_idx_d;

   always_comb begin
      bar_cnt_d = bar_cnt_q + CW'(1);
      bar_idx_d = bar_idx_q;
      if (pixel_x == 10'd0) begin
         bar_cnt_d = '0;
         bar_idx_d = 3'd0;
      end else if (bar_cnt_q == BAR_LAST) begin
         bar_cnt_d = '0;
         bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bar_cnt_q <= '0;
         bar_idx_q <= 3'd0;
      end else if (p_tick) begin
         bar_cnt_q <= bar_cnt_d;
         bar_idx_q <= bar_idx_d;
      end
   end

   // ------------------------------------------------------------------------
   // Pattern mux. Uses mode_d so the first pixel of a frame already shows the
   // pattern selected at that frame start; mode_d only differs from mode_q on
   // a frame-start cycle.
   // ------------------------------------------------------------------------
   logic [2:0] pattern;
   logic [2:0] rgb_d;
   logic [2:0] rgb_q;
   logic       on_border;

   assign on_border = (pixel_x == 10'd0) || (pixel_x == X_LAST) ||
                      (pixel_y == 10'd0) || (pixel_y == Y_LAST);

   always_comb begin
      pattern = COLOR_BLACK;
      case (mode_d)
         MODE_SOLID:   pattern = sw;
         MODE_VBARS:   pattern = bar_idx_d;
         MODE_HBARS:   pattern = pixel_y[8:6];
         MODE_CHECKER: pattern = (pixel_x[5] ^ pixel_y[5]) ? COLOR_WHITE : COLOR_BLACK;
         MODE_BORDER:  pattern = on_border ? COLOR_WHITE : COLOR_BLACK;
         default:      pattern = COLOR_BLACK;
      endcase
`ifdef VGA_PATTERN_CROSSHAIR_EN
      if ((pixel_x == 10'(H_ACTIVE / 2)) || (pixel_y == 10'(V_ACTIVE / 2)))
         pattern = COLOR_WHITE;
`endif
      rgb_d = video_on ? pattern : COLOR_BLACK;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rgb_q <= COLOR_BLACK;
      else if (p_tick)
         rgb_q <= rgb_d;
   end

   assign rgb        = rgb_q;
   assign mode       = mode_q;
   assign frame_tick = frame_tick_q;

endmodule
